// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// muldiv_pkg
// Shared op encodings, FSM state type and constants for the mul/div unit.
// Revision: 1.0
// ============================================================================
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    // Replicated to operand width to form the divide-by-zero quotient.
    localparam logic c_divZeroQuotBit = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } mode_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// muldiv_step
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
// Revision: 1.0
// ============================================================================
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  mode_t                mode,
    input  logic [2*WIDTH-1:0]   partial,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   nextPartial
);

    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_mulNext;
    logic [WIDTH:0]     w_shRem;
    logic [WIDTH+1:0]   w_diff;
    logic               w_fits;
    logic [WIDTH-1:0]   w_newRem;
    logic [2*WIDTH-1:0] w_divNext;

    // Multiply: {hi, lo} with the multiplier consumed from lo's LSB; the add
    // carry becomes the new top bit as the register shifts right.
    assign w_addend  = partial[0] ? operand : '0;
    assign w_sum     = {1'b0, partial[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    assign w_mulNext = {w_sum, partial[WIDTH-1:1]};

    // Divide: {remainder, dividend/quotient}; quotient bits enter at the LSB.
    assign w_shRem   = partial[2*WIDTH-1:WIDTH-1];
    assign w_diff    = {1'b0, w_shRem} - {2'b00, operand};
    assign w_fits    = ~w_diff[WIDTH+1];
    assign w_newRem  = w_fits ? w_diff[WIDTH-1:0] : w_shRem[WIDTH-1:0];
    assign w_divNext = {w_newRem, partial[WIDTH-2:0], w_fits};

    assign nextPartial = (mode == MODE_DIV) ? w_divNext : w_mulNext;

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// muldiv_unit
// Iterative signed/unsigned multiply/divide with architectural Hi/Lo.
// Revision: 1.0
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] c_lastIter = CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_nextState;
    logic [CNT_W-1:0]   r_count;
    logic [2*WIDTH-1:0] r_partial;
    logic [WIDTH-1:0]   r_operand;
    mode_t              r_mode;
    logic               r_negQuot;
    logic               r_negRem;
    logic               r_divZero;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_accept;
    logic               w_mthi;
    logic               w_mtlo;
    logic               w_iter;
    logic               w_commit;

    logic               w_isDivOp;
    logic               w_signedOp;
    logic               w_aNeg;
    logic               w_bNeg;
    logic [WIDTH-1:0]   w_aMag;
    logic [WIDTH-1:0]   w_bMag;
    logic [2*WIDTH-1:0] w_stepOut;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fixHi;
    logic [WIDTH-1:0]   w_fixLo;

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_mthi      = 1'b0;
        w_mtlo      = 1'b0;
        w_iter      = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !cancel) begin
                    case (op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            w_accept    = 1'b1;
                            w_nextState = ST_RUN;
                        end
                        OP_MTHI: w_mthi = 1'b1;
                        OP_MTLO: w_mtlo = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (cancel) begin
                    w_nextState = ST_IDLE;
                end else begin
                    w_iter = 1'b1;
                    if (r_count == c_lastIter) begin
                        w_nextState = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                w_nextState = ST_IDLE;
                w_commit    = !cancel;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Operand conditioning and iteration datapath
    // ------------------------------------------------------------------------
    assign w_isDivOp  = (op == OP_DIV) || (op == OP_DIVU);
    assign w_signedOp = (op == OP_MULT) || (op == OP_DIV);
    assign w_aNeg     = w_signedOp & a[WIDTH-1];
    assign w_bNeg     = w_signedOp & b[WIDTH-1];
    assign w_aMag     = w_aNeg ? -a : a;
    assign w_bMag     = w_bNeg ? -b : b;

    muldiv_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .mode       (r_mode),
        .partial    (r_partial),
        .operand    (r_operand),
        .nextPartial(w_stepOut)
    );

    // Magnitude remainder of a zero divide is |a|; the dividend-sign fix
    // restores the original a, so only the quotient needs overriding.
    assign w_prod  = r_negQuot ? -r_partial : r_partial;
    assign w_quot  = r_partial[WIDTH-1:0];
    assign w_rem   = r_partial[2*WIDTH-1:WIDTH];

    always_comb begin
        w_fixHi = w_prod[2*WIDTH-1:WIDTH];
        w_fixLo = w_prod[WIDTH-1:0];
        if (r_mode == MODE_DIV) begin
            w_fixHi = r_negRem ? -w_rem : w_rem;
            if (r_divZero) begin
                w_fixLo = {WIDTH{c_divZeroQuotBit}};
            end else begin
                w_fixLo = r_negQuot ? -w_quot : w_quot;
            end
        end
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_count   <= '0;
            r_partial <= '0;
            r_operand <= '0;
            r_mode    <= MODE_MUL;
            r_negQuot <= 1'b0;
            r_negRem  <= 1'b0;
            r_divZero <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_commit;
            if (w_accept) begin
                r_count   <= '0;
                r_mode    <= w_isDivOp ? MODE_DIV : MODE_MUL;
                r_operand <= w_isDivOp ? w_bMag : w_aMag;
                r_partial <= {{WIDTH{1'b0}}, (w_isDivOp ? w_aMag : w_bMag)};
                r_negQuot <= w_aNeg ^ w_bNeg;
                r_negRem  <= w_aNeg;
                r_divZero <= w_isDivOp && (b == '0);
            end else if (w_iter) begin
                r_partial <= w_stepOut;
                r_count   <= r_count + CNT_W'(1);
            end
            if (w_commit) begin
                r_hi <= w_fixHi;
                r_lo <= w_fixLo;
            end else begin
                if (w_mthi) r_hi <= a;
                if (w_mtlo) r_lo <= a;
            end
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// tb_muldiv_unit
// Directed self-checking bench for muldiv_unit at WIDTH=32.
// Revision: 1.0
// ============================================================================
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk;
    logic        Reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int failures;

    muldiv_unit #(
        .WIDTH(32)
    ) dut (
        .clk   (clk),
        .Reset (Reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .cancel(cancel),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every task begins and ends 1 time unit after a rising edge.
    task automatic issue(input logic [2:0] opIn, input logic [31:0] aIn, input logic [31:0] bIn);
        start = 1'b1;
        op    = opIn;
        a     = aIn;
        b     = bIn;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'd7;
    endtask

    task automatic waitDone(output int lat, output int busyCnt);
        lat     = 0;
        busyCnt = busy ? 1 : 0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
            if (busy) busyCnt++;
        end
    endtask

    task automatic test_reset();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
        checks++; if (hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
    endtask

    task automatic test_mult();
        int lat, bc;
        issue(OP_MULT, 32'hFFFFFFFD, 32'd5);
        waitDone(lat, bc);
        checks++; if (lat !== 33) begin failures++; $display("FAIL mult_latency got=%0d exp=33", lat); end
        checks++; if (bc !== 33) begin failures++; $display("FAIL mult_busy_cycles got=%0d exp=33", bc); end
        checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
        checks++; if (lo !== 32'hFFFFFFF1) begin failures++; $display("FAIL mult_lo got=%h exp=fffffff1", lo); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL mult_done_pulse got=%0b exp=0", done); end
    endtask

    task automatic test_multu();
        int lat, bc;
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        waitDone(lat, bc);
        checks++; if (hi !== 32'hFFFFFFFE) begin failures++; $display("FAIL multu_hi got=%h exp=fffffffe", hi); end
        checks++; if (lo !== 32'h00000001) begin failures++; $display("FAIL multu_lo got=%h exp=00000001", lo); end
    endtask

    task automatic test_div();
        int lat, bc;
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
        waitDone(lat, bc);
        checks++; if (lat !== 33) begin failures++; $display("FAIL div_latency got=%0d exp=33", lat); end
        checks++; if (lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_quot got=%h exp=fffffffd", lo); end
        checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_rem got=%h exp=ffffffff", hi); end
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        waitDone(lat, bc);
        checks++; if (lo !== 32'h80000000) begin failures++; $display("FAIL div_ovf_quot got=%h exp=80000000", lo); end
        checks++; if (hi !== 32'h0) begin failures++; $display("FAIL div_ovf_rem got=%h exp=0", hi); end
    endtask

    task automatic test_divzero_mthi();
        int lat, bc;
        issue(OP_DIVU, 32'h00001234, 32'd0);
        waitDone(lat, bc);
        checks++; if (lat !== 33) begin failures++; $display("FAIL div0_latency got=%0d exp=33", lat); end
        checks++; if (lo !== 32'hFFFFFFFF) begin failures++; $display("FAIL div0_quot got=%h exp=ffffffff", lo); end
        checks++; if (hi !== 32'h00001234) begin failures++; $display("FAIL div0_rem got=%h exp=00001234", hi); end
        issue(OP_MTHI, 32'hCAFEF00D, 32'd0);
        checks++; if (hi !== 32'hCAFEF00D) begin failures++; $display("FAIL mthi_hi got=%h exp=cafef00d", hi); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mthi_busy got=%0b exp=0", busy); end
        checks++; if (lo !== 32'hFFFFFFFF) begin failures++; $display("FAIL mthi_lo_kept got=%h exp=ffffffff", lo); end
    endtask

    task automatic test_cancel();
        int sawDone;
        issue(OP_MTHI, 32'h11, 32'd0);
        issue(OP_MTLO, 32'h22, 32'd0);
        issue(OP_MULTU, 32'd7, 32'd9);
        repeat (9) begin @(posedge clk); #1; end
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL cancel_busy got=%0b exp=0", busy); end
        sawDone = 0;
        repeat (40) begin @(posedge clk); #1; if (done) sawDone++; end
        checks++; if (sawDone !== 0) begin failures++; $display("FAIL cancel_no_done got=%0d exp=0", sawDone); end
        checks++; if (hi !== 32'h11) begin failures++; $display("FAIL cancel_hi got=%h exp=00000011", hi); end
        checks++; if (lo !== 32'h22) begin failures++; $display("FAIL cancel_lo got=%h exp=00000022", lo); end
        // Cancel in IDLE drops a same-cycle start.
        cancel = 1'b1;
        issue(OP_MTLO, 32'h99, 32'd0);
        cancel = 1'b0;
        checks++; if (lo !== 32'h22) begin failures++; $display("FAIL cancel_idle_lo got=%h exp=00000022", lo); end
    endtask

    task automatic test_start_while_busy();
        int lat, bc;
        issue(OP_MULT, 32'd6, 32'd7);
        repeat (3) begin @(posedge clk); #1; end
        issue(OP_MTLO, 32'hDEAD, 32'd0);
        checks++; if (lo !== 32'h22) begin failures++; $display("FAIL busy_mtlo_ignored got=%h exp=00000022", lo); end
        waitDone(lat, bc);
        checks++; if (lat !== 29) begin failures++; $display("FAIL busy_mult_latency got=%0d exp=29", lat); end
        checks++; if (lo !== 32'd42) begin failures++; $display("FAIL busy_mult_lo got=%h exp=0000002a", lo); end
        checks++; if (hi !== 32'd0) begin failures++; $display("FAIL busy_mult_hi got=%h exp=0", hi); end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        issue(OP_MULTU, 32'd100, 32'd3);
        waitDone(lat, bc);
        // Issue in the cycle done is high.
        issue(OP_DIVU, 32'd100, 32'd7);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got=%0b exp=1", busy); end
        waitDone(lat, bc);
        checks++; if (lat !== 33) begin failures++; $display("FAIL b2b_latency got=%0d exp=33", lat); end
        checks++; if (lo !== 32'd14) begin failures++; $display("FAIL b2b_quot got=%h exp=0000000e", lo); end
        checks++; if (hi !== 32'd2) begin failures++; $display("FAIL b2b_rem got=%h exp=00000002", hi); end
    endtask

    task automatic test_reset_mid();
        int lat, bc;
        issue(OP_MULTU, 32'd5, 32'd5);
        repeat (4) begin @(posedge clk); #1; end
        #2;
        Reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%0b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%0b exp=0", done); end
        checks++; if (hi !== 32'h0) begin failures++; $display("FAIL rstmid_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'h0) begin failures++; $display("FAIL rstmid_lo got=%h exp=0", lo); end
        @(negedge clk);
        Reset = 1'b1;
        @(posedge clk); #1;
        issue(OP_MULTU, 32'd3, 32'd4);
        waitDone(lat, bc);
        checks++; if (lat !== 33) begin failures++; $display("FAIL rstmid_latency got=%0d exp=33", lat); end
        checks++; if (lo !== 32'd12) begin failures++; $display("FAIL rstmid_lo_result got=%h exp=0000000c", lo); end
        checks++; if (hi !== 32'd0) begin failures++; $display("FAIL rstmid_hi_result got=%h exp=0", hi); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        Reset    = 1'b0;
        start    = 1'b0;
        op       = 3'd7;
        a        = '0;
        b        = '0;
        cancel   = 1'b0;
        #12;
        test_reset();
        @(negedge clk);
        Reset = 1'b1;
        @(posedge clk); #1;
        test_mult();
        test_multu();
        test_div();
        test_divzero_mthi();
        test_cancel();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
